// File: rtl/fdiv_iter.sv
// fdiv_iter: parameterised IEEE-754-style floating-point divider.
// Restoring radix-2 division, one quotient bit per cycle, round to nearest
// even, denormal inputs flushed to zero and tiny results flushed to zero.
//
// state  | meaning
// IDLE   | ready for operands; unpack and classify on accept
// DIVIDE | one restoring-division step per cycle, MAN_W+3 steps
// ROUND  | normalise, round, range-check (or emit the special result)
// DONE   | result presented, held until out_ready
module fdiv_iter #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);

  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int M  = MAN_W + 1;
  localparam int N  = MAN_W + 3;
  localparam int EW = EXP_W + 2;
  localparam int CW = $clog2(N + 1);

  localparam logic [EXP_W-1:0]    EXP_ONES = '1;
  localparam logic signed [EW-1:0] BIAS    = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EXP_MAX = EW'((1 << EXP_W) - 1);
  localparam logic [CW-1:0]       ITERS    = CW'(N);
  localparam logic [W-1:0]        QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

  state_t                 state;
  logic                   sign_q;
  logic signed [EW-1:0]   exp_q;
  logic [M-1:0]           den_q;
  logic [M:0]             rem_q;
  logic [N-1:0]           quo_q;
  logic [CW-1:0]          cnt_q;
  logic                   spec_q;
  logic [W-1:0]           spec_res_q;
  logic [3:0]             spec_flg_q;

  logic                   a_sign, b_sign, sign_in;
  logic [EXP_W-1:0]       a_exp, b_exp;
  logic [MAN_W-1:0]       a_frac, b_frac;
  logic                   a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign a_sign  = a[W-1];
  assign b_sign  = b[W-1];
  assign a_exp   = a[W-2:MAN_W];
  assign b_exp   = b[W-2:MAN_W];
  assign a_frac  = a[MAN_W-1:0];
  assign b_frac  = b[MAN_W-1:0];
  assign sign_in = a_sign ^ b_sign;

  // A zero exponent covers both true zeros and flushed denormals.
  assign a_zero = (a_exp == '0);
  assign b_zero = (b_exp == '0);
  assign a_inf  = (a_exp == EXP_ONES) && (a_frac == '0);
  assign b_inf  = (b_exp == EXP_ONES) && (b_frac == '0);
  assign a_nan  = (a_exp == EXP_ONES) && (a_frac != '0);
  assign b_nan  = (b_exp == EXP_ONES) && (b_frac != '0);

  assign in_ready = (state == IDLE);

  logic           spec_hit;
  logic [W-1:0]   spec_res;
  logic [3:0]     spec_flg;

  // Special-operand classification, resolved in priority order.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res = QNAN;
      spec_flg = 4'b1000;
    end else if (a_inf) begin
      spec_res = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
    end else if (b_zero) begin
      spec_res = {sign_in, EXP_ONES, {MAN_W{1'b0}}};
      spec_flg = 4'b0100;
    end else if (a_zero || b_inf) begin
      spec_res = {sign_in, {(W-1){1'b0}}};
    end else begin
      spec_hit = 1'b0;
    end
  end

  logic           q_bit;
  logic [M:0]     rem_diff;

  // One restoring-division step: subtract the divisor when it fits.
  always_comb begin
    q_bit    = (rem_q >= {1'b0, den_q});
    rem_diff = q_bit ? (rem_q - {1'b0, den_q}) : rem_q;
  end

  logic [MAN_W-1:0]       frac_k, frac_r;
  logic                   guard, sticky, round_up, carry;
  logic signed [EW-1:0]   e_n, e_r;
  logic [W-1:0]           rnd_res;
  logic [3:0]             rnd_flg;

  // Normalise the quotient, round to nearest even, then range-check.
  always_comb begin
    if (quo_q[N-1]) begin
      frac_k = quo_q[N-2:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != '0);
      e_n    = exp_q;
    end else begin
      frac_k = quo_q[N-3:1];
      guard  = quo_q[0];
      sticky = (rem_q != '0);
      e_n    = exp_q - EW'(1);
    end
    round_up        = guard & (sticky | frac_k[0]);
    {carry, frac_r} = {1'b0, frac_k} + {{MAN_W{1'b0}}, round_up};
    // A carry out of the fraction means 1.11..1 rounded up to 10.0; the
    // fraction is already zero so only the exponent moves.
    e_r     = e_n + $signed({{(EW-1){1'b0}}, carry});
    rnd_res = {sign_q, e_r[EXP_W-1:0], frac_r};
    rnd_flg = '0;
    if (e_r >= EXP_MAX) begin
      rnd_res = {sign_q, EXP_ONES, {MAN_W{1'b0}}};
      rnd_flg = 4'b0010;
    end else if (e_r <= EW'(0)) begin
      rnd_res = {sign_q, {(W-1){1'b0}}};
      rnd_flg = 4'b0001;
    end
  end

  // Control FSM with registered result and handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out        <= '0;
      flags      <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      den_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      spec_q     <= 1'b0;
      spec_res_q <= '0;
      spec_flg_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_q     <= sign_in;
            exp_q      <= $signed({2'b00, a_exp}) - $signed({2'b00, b_exp}) + BIAS;
            den_q      <= {1'b1, b_frac};
            rem_q      <= {2'b01, a_frac};
            quo_q      <= '0;
            cnt_q      <= ITERS;
            spec_q     <= spec_hit;
            spec_res_q <= spec_res;
            spec_flg_q <= spec_flg;
            state      <= spec_hit ? ROUND : DIVIDE;
          end
        end
        DIVIDE: begin
          quo_q <= {quo_q[N-2:0], q_bit};
          rem_q <= rem_diff << 1;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state <= ROUND;
        end
        ROUND: begin
          out       <= spec_q ? spec_res_q : rnd_res;
          flags     <= spec_q ? spec_flg_q : rnd_flg;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
